// File: rtl/avalon_slave.sv
// rtl/avalon_slave.sv - Avalon-MM register slave feeding FFT sample memory and start control
module avalon_slave (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        slave_chipselect,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [8:0]  slave_address,
    input  logic [15:0] slave_writedata,
    output logic [15:0] slave_readdata,
    output logic        sWriteEn,
    output logic [8:0]  wAddress,
    output logic [15:0] fft_init_data,
    output logic        fft_start
);

    localparam logic [8:0] ADDR_LAST_SAMPLE = 9'h0FF;
    localparam logic [8:0] ADDR_CTRL        = 9'h100;
    localparam logic [8:0] ADDR_STAT        = 9'h101;
    localparam logic [8:0] COUNT_MAX        = 9'd256;

    logic        r_wr_prev;
    logic [8:0]  r_loaded_count;
    logic        r_auto_start;
    logic        r_auto_pend;
    logic        r_sWriteEn;
    logic [8:0]  r_wAddress;
    logic [15:0] r_fft_init_data;
    logic        r_fft_start;
    logic [15:0] r_readdata;

    logic        w_wr_level;
    logic        w_wr_accept;
    logic        w_sample_wr;
    logic        w_ctrl_wr;
    logic        w_start_req;
    logic        w_rd;
    logic [15:0] w_rd_mux;

    // A held write strobe counts once: accept only on its rising edge.
    assign w_wr_level  = slave_chipselect & slave_write;
    assign w_wr_accept = w_wr_level & ~r_wr_prev;
    assign w_sample_wr = w_wr_accept & ~slave_address[8];
    assign w_ctrl_wr   = w_wr_accept & (slave_address == ADDR_CTRL);
    assign w_start_req = w_ctrl_wr & slave_writedata[0];
    assign w_rd        = slave_chipselect & slave_read;

    // Remember last cycle's write level for edge detection.
    always_ff @(posedge clk) begin
        if (n_rst) r_wr_prev <= 1'b0;
        else       r_wr_prev <= w_wr_level;
    end

    // Sample path: one-cycle write pulse; address/data hold between pulses.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_sWriteEn      <= 1'b0;
            r_wAddress      <= 9'd0;
            r_fft_init_data <= 16'd0;
        end else begin
            r_sWriteEn <= w_sample_wr;
            if (w_sample_wr) begin
                r_wAddress      <= slave_address;
                r_fft_init_data <= slave_writedata;
            end
        end
    end

    // Control register and start generation; auto-start fires one cycle after the last-sample pulse.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_auto_start <= 1'b0;
            r_auto_pend  <= 1'b0;
            r_fft_start  <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_auto_start <= slave_writedata[1];
            r_auto_pend <= w_sample_wr & r_auto_start & (slave_address == ADDR_LAST_SAMPLE);
            r_fft_start <= w_start_req | r_auto_pend;
        end
    end

    // Loaded-sample counter: saturates at 256, cleared by a manual start.
    always_ff @(posedge clk) begin
        if (n_rst)
            r_loaded_count <= 9'd0;
        else if (w_start_req)
            r_loaded_count <= 9'd0;
        else if (w_sample_wr && (r_loaded_count != COUNT_MAX))
            r_loaded_count <= r_loaded_count + 9'd1;
    end

    // Read decode of the current register values.
    always_comb begin
        w_rd_mux = 16'h0000;
        case (slave_address)
            ADDR_CTRL: w_rd_mux = {14'b0, r_auto_start, 1'b0};
            ADDR_STAT: w_rd_mux = {7'b0, r_loaded_count};
            default:   w_rd_mux = 16'h0000;
        endcase
    end

    // Registered read data with one-cycle latency; holds when idle.
    always_ff @(posedge clk) begin
        if (n_rst)     r_readdata <= 16'h0000;
        else if (w_rd) r_readdata <= w_rd_mux;
    end

    assign slave_readdata = r_readdata;
    assign sWriteEn       = r_sWriteEn;
    assign wAddress       = r_wAddress;
    assign fft_init_data  = r_fft_init_data;
    assign fft_start      = r_fft_start;

endmodule

// File: tb/tb_avalon_slave.sv
// tb/tb_avalon_slave.sv - self-checking bench for avalon_slave
module tb_avalon_slave;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cs, rd, wr;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] readdata;
    logic        swe;
    logic [8:0]  waddr;
    logic [15:0] fdata;
    logic        fstart;

    avalon_slave dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .slave_chipselect (cs),
        .slave_read       (rd),
        .slave_write      (wr),
        .slave_address    (addr),
        .slave_writedata  (wdata),
        .slave_readdata   (readdata),
        .sWriteEn         (swe),
        .wAddress         (waddr),
        .fft_init_data    (fdata),
        .fft_start        (fstart)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int swe_seen = 0;

    // Reference model: transaction-level state plus a schedule of start pulses keyed by edge number.
    int          cyc = 0;
    bit          m_prev = 0;
    int          m_count = 0;
    bit          m_auto = 0;
    logic [15:0] m_rd = 0;
    logic [8:0]  m_waddr = 0;
    logic [15:0] m_fdata = 0;
    bit          sched[int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic apply(input bit r, input bit c, input bit rdi, input bit wri,
                         input logic [8:0] a, input logic [15:0] d);
        bit acc;
        bit e_swe;
        bit e_fft;
        n_rst = r; cs = c; rd = rdi; wr = wri; addr = a; wdata = d;
        @(posedge clk);
        #1;
        e_swe = 0;
        if (r) begin
            m_prev = 0; m_count = 0; m_auto = 0; m_rd = 0; m_waddr = 0; m_fdata = 0;
            sched.delete();
        end else begin
            if (c && rdi) begin
                if (a == 9'h100)      m_rd = {14'b0, m_auto, 1'b0};
                else if (a == 9'h101) m_rd = 16'(m_count);
                else                  m_rd = 16'h0000;
            end
            acc = c && wri && !m_prev;
            m_prev = c && wri;
            if (acc && a < 9'h100) begin
                e_swe = 1; m_waddr = a; m_fdata = d;
                if (m_count < 256) m_count++;
                if (m_auto && a == 9'h0FF) sched[cyc + 1] = 1;
            end else if (acc && a == 9'h100) begin
                m_auto = d[1];
                if (d[0]) begin
                    sched[cyc] = 1;
                    m_count = 0;
                end
            end
        end
        e_fft = sched.exists(cyc);
        if (e_fft) sched.delete(cyc);
        cyc++;
        if (swe === 1'b1) swe_seen++;
        chk("sWriteEn", 32'(swe), 32'(e_swe));
        chk("wAddress", 32'(waddr), 32'(m_waddr));
        chk("fft_init_data", 32'(fdata), 32'(m_fdata));
        chk("fft_start", 32'(fstart), 32'(e_fft));
        chk("slave_readdata", 32'(readdata), 32'(m_rd));
    endtask

    typedef struct {
        bit          rst, cs, rd, wr;
        logic [8:0]  a;
        logic [15:0] d;
        bit          e_swe;
        logic [8:0]  e_wa;
        logic [15:0] e_fd;
        bit          e_fft;
        logic [15:0] e_rd;
    } vec_t;

    function automatic vec_t mk(bit r, bit c, bit rdi, bit wri, logic [8:0] a, logic [15:0] d,
                                bit es, logic [8:0] ew, logic [15:0] ed, bit ef, logic [15:0] er);
        vec_t v;
        v.rst = r; v.cs = c; v.rd = rdi; v.wr = wri; v.a = a; v.d = d;
        v.e_swe = es; v.e_wa = ew; v.e_fd = ed; v.e_fft = ef; v.e_rd = er;
        return v;
    endfunction

    vec_t tbl[28];

    initial begin
        n_rst = 1; cs = 0; rd = 0; wr = 0; addr = 0; wdata = 0;

        //              rst cs rd wr addr    data      swe wa      fd        fft rd
        tbl[0]  = mk(1, 0, 0, 0, 9'h000, 16'h0000, 0, 9'h000, 16'h0000, 0, 16'h0000);
        tbl[1]  = mk(1, 1, 0, 1, 9'h000, 16'hF0F0, 0, 9'h000, 16'h0000, 0, 16'h0000);
        tbl[2]  = mk(0, 1, 0, 1, 9'h000, 16'hF0F0, 1, 9'h000, 16'hF0F0, 0, 16'h0000);
        tbl[3]  = mk(0, 1, 0, 1, 9'h000, 16'hF0F0, 0, 9'h000, 16'hF0F0, 0, 16'h0000);
        tbl[4]  = mk(0, 1, 0, 1, 9'h000, 16'hF0F0, 0, 9'h000, 16'hF0F0, 0, 16'h0000);
        tbl[5]  = mk(0, 0, 0, 0, 9'h000, 16'h0000, 0, 9'h000, 16'hF0F0, 0, 16'h0000);
        tbl[6]  = mk(0, 1, 1, 0, 9'h101, 16'h0000, 0, 9'h000, 16'hF0F0, 0, 16'h0001);
        tbl[7]  = mk(0, 0, 0, 0, 9'h000, 16'h0000, 0, 9'h000, 16'hF0F0, 0, 16'h0001);
        tbl[8]  = mk(0, 1, 0, 1, 9'h1AB, 16'h1234, 0, 9'h000, 16'hF0F0, 0, 16'h0001);
        tbl[9]  = mk(0, 0, 0, 1, 9'h005, 16'h5555, 0, 9'h000, 16'hF0F0, 0, 16'h0001);
        tbl[10] = mk(0, 0, 0, 0, 9'h000, 16'h0000, 0, 9'h000, 16'hF0F0, 0, 16'h0001);
        tbl[11] = mk(0, 1, 1, 0, 9'h101, 16'h0000, 0, 9'h000, 16'hF0F0, 0, 16'h0001);
        tbl[12] = mk(0, 1, 0, 1, 9'h100, 16'h0003, 0, 9'h000, 16'hF0F0, 1, 16'h0001);
        tbl[13] = mk(0, 0, 0, 0, 9'h000, 16'h0000, 0, 9'h000, 16'hF0F0, 0, 16'h0001);
        tbl[14] = mk(0, 1, 1, 0, 9'h100, 16'h0000, 0, 9'h000, 16'hF0F0, 0, 16'h0002);
        tbl[15] = mk(0, 1, 1, 0, 9'h101, 16'h0000, 0, 9'h000, 16'hF0F0, 0, 16'h0000);
        tbl[16] = mk(0, 1, 0, 1, 9'h0FF, 16'hABCD, 1, 9'h0FF, 16'hABCD, 0, 16'h0000);
        tbl[17] = mk(0, 0, 0, 0, 9'h000, 16'h0000, 0, 9'h0FF, 16'hABCD, 1, 16'h0000);
        tbl[18] = mk(0, 0, 0, 0, 9'h000, 16'h0000, 0, 9'h0FF, 16'hABCD, 0, 16'h0000);
        tbl[19] = mk(0, 1, 1, 1, 9'h100, 16'h0001, 0, 9'h0FF, 16'hABCD, 1, 16'h0002);
        tbl[20] = mk(0, 0, 0, 0, 9'h000, 16'h0000, 0, 9'h0FF, 16'hABCD, 0, 16'h0002);
        tbl[21] = mk(0, 1, 1, 0, 9'h100, 16'h0000, 0, 9'h0FF, 16'hABCD, 0, 16'h0000);
        tbl[22] = mk(0, 1, 0, 1, 9'h100, 16'h0002, 0, 9'h0FF, 16'hABCD, 0, 16'h0000);
        tbl[23] = mk(0, 0, 0, 0, 9'h000, 16'h0000, 0, 9'h0FF, 16'hABCD, 0, 16'h0000);
        tbl[24] = mk(0, 1, 0, 1, 9'h0FF, 16'h7777, 1, 9'h0FF, 16'h7777, 0, 16'h0000);
        tbl[25] = mk(1, 0, 0, 0, 9'h000, 16'h0000, 0, 9'h000, 16'h0000, 0, 16'h0000);
        tbl[26] = mk(0, 0, 0, 0, 9'h000, 16'h0000, 0, 9'h000, 16'h0000, 0, 16'h0000);
        tbl[27] = mk(0, 1, 1, 0, 9'h100, 16'h0000, 0, 9'h000, 16'h0000, 0, 16'h0000);

        for (int i = 0; i < 28; i++) begin
            apply(tbl[i].rst, tbl[i].cs, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
            chk($sformatf("vec%0d.swe", i), 32'(swe), 32'(tbl[i].e_swe));
            chk($sformatf("vec%0d.waddr", i), 32'(waddr), 32'(tbl[i].e_wa));
            chk($sformatf("vec%0d.fdata", i), 32'(fdata), 32'(tbl[i].e_fd));
            chk($sformatf("vec%0d.fft", i), 32'(fstart), 32'(tbl[i].e_fft));
            chk($sformatf("vec%0d.rd", i), 32'(readdata), 32'(tbl[i].e_rd));
        end

        // Fill all 256 samples (3-cycle hold, 1-cycle gap), then check count and saturation.
        apply(1, 0, 0, 0, 9'h000, 16'h0000);
        swe_seen = 0;
        for (int a = 0; a < 256; a++) begin
            for (int h = 0; h < 3; h++) apply(0, 1, 0, 1, 9'(a), 16'hF0F0);
            apply(0, 0, 0, 0, 9'h000, 16'h0000);
        end
        chk("fill_pulses", 32'(swe_seen), 32'd256);
        apply(0, 1, 1, 0, 9'h101, 16'h0000);
        chk("fill_status", 32'(readdata), 32'h0100);
        apply(0, 1, 0, 1, 9'h010, 16'h1111);
        apply(0, 0, 0, 0, 9'h000, 16'h0000);
        apply(0, 1, 1, 0, 9'h101, 16'h0000);
        chk("saturate_status", 32'(readdata), 32'h0100);
        apply(0, 1, 0, 1, 9'h100, 16'h0001);
        chk("manual_start", 32'(fstart), 32'd1);
        apply(0, 1, 1, 0, 9'h101, 16'h0000);
        chk("status_cleared", 32'(readdata), 32'h0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [8:0]  ra;
            logic [15:0] rdv;
            int sel;
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: ra = 9'h0FF;
                1: ra = 9'h100;
                2: ra = 9'h101;
                3: ra = 9'($urandom_range(9'h102, 9'h1FF));
                default: ra = 9'($urandom_range(0, 255));
            endcase
            rdv = 16'($urandom);
            apply($urandom_range(0, 63) == 0, $urandom_range(0, 4) != 0,
                  1'($urandom), 1'($urandom), ra, rdv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_slave.md
AVALON_SLAVE -- requirements
Module: avalon_slave

Interface
REQ-001 SHALL use one clock and one reset: the reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 n_rst  input  1  synchronous reset, active-high (1 = reset on next clk edge).
REQ-004 slave_chipselect  input  1  Avalon-MM chip select; qualifies read/write.
REQ-005 slave_read  input  1  Avalon-MM read strobe.
REQ-006 slave_write  input  1  Avalon-MM write strobe.
REQ-007 slave_address  input  9  word address: 0x000-0x0FF sample buffer, 0x100 control, 0x101 status, 0x102-0x1FF reserved.
REQ-008 slave_writedata  input  16  Avalon-MM write data.
REQ-009 slave_readdata  output  16  registered read data.
REQ-010 sWriteEn  output  1  one-cycle write-enable pulse to the FFT sample memory.
REQ-011 wAddress  output  9  sample-memory address accompanying sWriteEn.
REQ-012 fft_init_data  output  16  sample data accompanying sWriteEn.
REQ-013 fft_start  output  1  one-cycle FFT start pulse.

Function
REQ-014 Write transaction = cycle where chipselect&write is 1 and was 0 in the previous cycle (rising-edge detect); write held N cycles counts once.
REQ-015 Sample write (address 0x000-0x0FF): cycle after acceptance, sWriteEn=1 for exactly one cycle, wAddress=address, fft_init_data=writedata.
REQ-016 wAddress and fft_init_data hold their last values when sWriteEn=0.
REQ-017 Loaded counter (9 bits) increments once per accepted sample write, saturates at 256; rewrites of the same address still increment.
REQ-018 Control write (0x100): bit0=1 requests start (self-clearing, not stored); bit1 stored as auto_start; other bits ignored.
REQ-019 Start request: fft_start=1 for exactly one cycle, the cycle after acceptance; loaded counter clears to 0 in the same cycle.
REQ-020 Auto-start: if auto_start=1 and a sample write to 0x0FF is accepted, fft_start pulses one cycle after that write's sWriteEn pulse (two cycles after acceptance).
REQ-021 Auto-start and manual start coinciding in the same cycle produce a single one-cycle fft_start pulse.
REQ-022 Writes to 0x101-0x1FF are ignored (no sWriteEn, no state change).
REQ-023 Read: when chipselect&read is 1, slave_readdata updates on the next edge (latency 1); 0x100 -> {14'b0, auto_start, 1'b0}; 0x101 -> {7'b0, loaded_count}; all other addresses -> 0x0000.
REQ-024 slave_readdata holds its value when no read is active.
REQ-025 Read and write asserted together: both are serviced independently.
REQ-026 chipselect=0: read and write strobes are ignored.

Reset
REQ-027 While n_rst=1 at a clk edge: sWriteEn=0, fft_start=0, wAddress=0, fft_init_data=0, slave_readdata=0, loaded counter=0, auto_start=0, write edge detector=0.
REQ-028 Reset takes priority over every transaction; a pending output pulse is cancelled.
REQ-029 A write held asserted through reset release is accepted once, on the first cycle with n_rst=0.

Verification
REQ-030 Reset, then write 0xF0F0 to 0x000 with write+chipselect held 3 cycles -> exactly one sWriteEn pulse, wAddress=0x000, fft_init_data=0xF0F0.
REQ-031 Write 0xF0F0 to addresses 0..255, each held 3 cycles with a 1-cycle gap -> 256 sWriteEn pulses with matching wAddress; read 0x101 -> 0x0100.
REQ-032 Write 0x0001 to 0x100 -> one fft_start pulse the next cycle; read 0x101 -> 0x0000; read 0x100 -> 0x0000.
REQ-033 Write 0x0002 to 0x100, then write sample to 0x0FF -> sWriteEn, then fft_start exactly one cycle later; read 0x100 -> 0x0002.
REQ-034 Write to 0x1AB, or any write with chipselect=0 -> no sWriteEn, no fft_start, status unchanged.
REQ-035 Assert n_rst during a sample write -> no sWriteEn; all outputs 0 the cycle after reset.
